// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state codes,
// default parameter values and the output record layout.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP   = 32'd4;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_RUN  = 2'd1;
  localparam fetch_state_t ST_HALT = 2'd2;

  // {pc, instr} record as seen by decode, at the default widths
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_rec_t;

endpackage

// File: rtl/fetch_out_stage.sv
// Single output register between the ROM and decode. Load captures a new
// {pc, instr}; flush drops valid but leaves the data untouched; otherwise hold.
module fetch_out_stage #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic [INSTR_W-1:0] next_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  // output register: reset clears all, load wins over flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= next_pc;
      instr <= next_instr;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a combinational instruction ROM. Owns the PC, presents
// it as the ROM address and registers each returned word into one output
// stage with a valid/ready handshake to decode.
// Optional build macro: FETCH_PERF_EN adds PERF_FETCHED / PERF_STALLS counters.
//
// state | meaning
// IDLE  | PC parked at RESET_PC, waiting for START; REDIRECT ignored
// RUN   | fetching one word per free output slot
// HALT  | halt word seen, no fetch; START or REDIRECT resumes
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(DEF_PC_STEP),
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(DEF_HALT_WORD)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [ADDR_W-1:0]  IM_ADDR,
  input  logic [INSTR_W-1:0] IM_RD,
  input  logic               REDIRECT,
  input  logic [ADDR_W-1:0]  REDIRECT_PC,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [INSTR_W-1:0] OUT_INSTR,
  output logic [ADDR_W-1:0]  OUT_PC,
  output logic               BUSY,
  output logic               HALTED
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        PERF_FETCHED,
  output logic [31:0]        PERF_STALLS
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_target;
  logic              redirect_pc_unused;
  logic              slot;
  logic              redirect_take;
  logic              start_take;
  logic              halt_word;
  logic              load;
  logic              flush;

  assign IM_ADDR = pc;
  assign BUSY    = (state == ST_RUN);
  assign HALTED  = (state == ST_HALT);

  // instructions are word aligned; the low target bits are dropped
  assign redirect_target    = {REDIRECT_PC[ADDR_W-1:2], 2'b00};
  assign redirect_pc_unused = ^REDIRECT_PC[1:0];

  assign slot          = (state == ST_RUN) && (!OUT_VALID || OUT_READY);
  assign redirect_take = REDIRECT && (state != ST_IDLE);
  assign start_take    = START && !redirect_take &&
                         ((state == ST_IDLE) || (state == ST_HALT));
  assign halt_word     = (IM_RD == HALT_WORD);

  // redirect suppresses the ROM capture; a halt word is never delivered
  assign load  = !redirect_take && slot && !halt_word;
  assign flush = redirect_take
              || (slot && halt_word)
              || ((state == ST_HALT) && (START || OUT_READY));

  // FSM and PC: redirect outranks fetch, halt and START
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else if (redirect_take) begin
      state <= ST_RUN;
      pc    <= redirect_target;
    end else begin
      case (state)
        ST_IDLE: begin
          pc <= RESET_PC;
          if (START) state <= ST_RUN;
        end
        ST_RUN: begin
          if (slot) begin
            if (halt_word) state <= ST_HALT;
            else           pc    <= pc + PC_STEP;
          end
        end
        ST_HALT: begin
          if (START) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
          end
        end
        default: begin
          state <= ST_IDLE;
          pc    <= RESET_PC;
        end
      endcase
    end
  end

  fetch_out_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out_stage (
    .clk        (CLK),
    .rst        (RST),
    .load       (load),
    .flush      (flush),
    .next_pc    (pc),
    .next_instr (IM_RD),
    .valid      (OUT_VALID),
    .pc         (OUT_PC),
    .instr      (OUT_INSTR)
  );

`ifdef FETCH_PERF_EN
  // delivered-word and backpressure-cycle counters, cleared by a restart
  always_ff @(posedge CLK) begin
    if (RST || start_take) begin
      PERF_FETCHED <= '0;
      PERF_STALLS  <= '0;
    end else begin
      if (OUT_VALID && OUT_READY)
        PERF_FETCHED <= PERF_FETCHED + 32'd1;
      if ((state == ST_RUN) && OUT_VALID && !OUT_READY)
        PERF_STALLS <= PERF_STALLS + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed vector table, a PC-wrap
// sequence and a randomized run against a transaction-level reference model.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] W0 = 32'h020081E0;
  localparam logic [31:0] W1 = 32'h021044E0;
  localparam logic [31:0] W2 = 32'h014003E0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] IM_ADDR;
  logic [31:0] IM_RD;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;
  logic        BUSY;
  logic        HALTED;
`ifdef FETCH_PERF_EN
  logic [31:0] PERF_FETCHED;
  logic [31:0] PERF_STALLS;
`endif

  logic [31:0] rom_mem [0:15];
  logic [31:0] wrap_word = '0;

  assign IM_RD = (IM_ADDR == 32'hFFFF_FFFC) ? wrap_word :
                 (IM_ADDR < 32'd64)         ? rom_mem[IM_ADDR[5:2]] : 32'h0;

  always #5 CLK = ~CLK;

  instr_fetch_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .IM_ADDR     (IM_ADDR),
    .IM_RD       (IM_RD),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_INSTR   (OUT_INSTR),
    .OUT_PC      (OUT_PC),
    .BUSY        (BUSY),
    .HALTED      (HALTED)
`ifdef FETCH_PERF_EN
    ,
    .PERF_FETCHED(PERF_FETCHED),
    .PERF_STALLS (PERF_STALLS)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode = M_IDLE;
  logic [31:0] m_pc = '0;
  bit          m_ov = 1'b0;
  fetch_rec_t  m_out = '0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_stalls = '0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return wrap_word;
    if (a < 32'd64) return rom_mem[a[5:2]];
    return 32'h0;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit rd,
                            input logic [31:0] rpc, input bit rdy);
    logic [31:0] w;
    if (r) begin
      m_mode = M_IDLE; m_pc = 0; m_ov = 0; m_out = '0;
      m_fetched = 0; m_stalls = 0;
      return;
    end
    if (m_ov && rdy) m_fetched = m_fetched + 1;
    if (m_mode == M_RUN && m_ov && !rdy) m_stalls = m_stalls + 1;
    if (st && (m_mode == M_IDLE || (m_mode == M_HALT && !rd))) begin
      m_fetched = 0; m_stalls = 0;
    end
    if (rd && m_mode != M_IDLE) begin
      m_pc = rpc & ~32'd3; m_ov = 0; m_mode = M_RUN;
    end else if (m_mode == M_IDLE) begin
      m_pc = 0;
      if (st) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!m_ov || rdy) begin
        w = rom_word(m_pc);
        if (w != 0) begin
          m_out.pc = m_pc; m_out.instr = w; m_ov = 1; m_pc = m_pc + 4;
        end else begin
          m_ov = 0; m_mode = M_HALT;
        end
      end
    end else begin
      if (st) begin
        m_mode = M_RUN; m_pc = 0; m_ov = 0;
      end else if (rdy) begin
        m_ov = 0;
      end
    end
  endtask

  // one clock: drive inputs, advance model, sample DUT 1 ns after the edge
  task automatic cycle(input string tag, input bit r, input bit st, input bit rd,
                       input logic [31:0] rpc, input bit rdy);
    RST = r; START = st; REDIRECT = rd; REDIRECT_PC = rpc; OUT_READY = rdy;
    model_step(r, st, rd, rpc, rdy);
    @(posedge CLK);
    #1;
    chk({tag, " model valid"}, 32'(OUT_VALID), 32'(m_ov));
    chk({tag, " model addr"}, IM_ADDR, m_pc);
    chk({tag, " model busy"}, 32'(BUSY), 32'(m_mode == M_RUN));
    chk({tag, " model halted"}, 32'(HALTED), 32'(m_mode == M_HALT));
    if (m_ov || r) begin
      chk({tag, " model pc"}, OUT_PC, m_out.pc);
      chk({tag, " model instr"}, OUT_INSTR, m_out.instr);
    end
`ifdef FETCH_PERF_EN
    chk({tag, " model fetched"}, PERF_FETCHED, m_fetched);
    chk({tag, " model stalls"}, PERF_STALLS, m_stalls);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, start, redir;
    logic [31:0] rpc;
    bit          ready;
    bit          e_valid;
    logic [31:0] e_pc, e_instr, e_addr;
    bit          e_busy, e_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit st, bit rd, logic [31:0] rpc, bit rdy,
                              bit ev, logic [31:0] epc, logic [31:0] ei,
                              logic [31:0] ea, bit eb, bit eh);
    vec_t v;
    v.rst = r; v.start = st; v.redir = rd; v.rpc = rpc; v.ready = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_addr = ea;
    v.e_busy = eb; v.e_halted = eh;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
    rom_mem[0] = W0; rom_mem[1] = W1; rom_mem[2] = W2;

    // straight run to halt
    add(1,0,0,0,1, 0,0,0,0,  0,0);
    add(0,1,0,0,1, 0,0,0,0,  1,0);
    add(0,0,0,0,1, 1,0,W0,4, 1,0);
    add(0,0,0,0,1, 1,4,W1,8, 1,0);
    add(0,0,0,0,1, 1,8,W2,12,1,0);
    add(0,0,0,0,1, 0,0,0,12, 0,1);
    // redirect from HALT with unaligned target 6 -> 4
    add(0,0,1,6,1, 0,0,0,4,  1,0);
    add(0,0,0,0,1, 1,4,W1,8, 1,0);
    add(0,0,0,0,1, 1,8,W2,12,1,0);
    add(0,0,0,0,1, 0,0,0,12, 0,1);
    // START in HALT restarts at 0
    add(0,1,0,0,1, 0,0,0,0,  1,0);
    add(0,0,0,0,1, 1,0,W0,4, 1,0);
    // reset while RUN with a valid word
    add(1,0,0,0,1, 0,0,0,0,  0,0);
    // redirect in IDLE is ignored
    add(0,0,1,8,1, 0,0,0,0,  0,0);
    add(0,0,0,0,1, 0,0,0,0,  0,0);
    // redirect over a stalled word at PC 4
    add(0,1,0,0,1, 0,0,0,0,  1,0);
    add(0,0,0,0,1, 1,0,W0,4, 1,0);
    add(0,0,0,0,1, 1,4,W1,8, 1,0);
    add(0,0,0,0,0, 1,4,W1,8, 1,0);
    add(0,0,1,8,0, 0,0,0,8,  1,0);
    add(0,0,0,0,1, 1,8,W2,12,1,0);
    add(0,0,0,0,1, 0,0,0,12, 0,1);
    // five-cycle backpressure on the first word
    add(1,0,0,0,1, 0,0,0,0,  0,0);
    add(0,1,0,0,1, 0,0,0,0,  1,0);
    add(0,0,0,0,1, 1,0,W0,4, 1,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 1,0,W0,4, 1,0);
    add(0,0,0,0,1, 1,4,W1,8, 1,0);
    add(0,0,0,0,1, 1,8,W2,12,1,0);
    add(0,0,0,0,1, 0,0,0,12, 0,1);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(t, vecs[i].rst, vecs[i].start, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      chk({t, " valid"}, 32'(OUT_VALID), 32'(vecs[i].e_valid));
      chk({t, " addr"}, IM_ADDR, vecs[i].e_addr);
      chk({t, " busy"}, 32'(BUSY), 32'(vecs[i].e_busy));
      chk({t, " halted"}, 32'(HALTED), 32'(vecs[i].e_halted));
      if (vecs[i].e_valid || vecs[i].rst) begin
        chk({t, " out_pc"}, OUT_PC, vecs[i].e_pc);
        chk({t, " out_instr"}, OUT_INSTR, vecs[i].e_instr);
      end
    end
`ifdef FETCH_PERF_EN
    chk("perf fetched at halt", PERF_FETCHED, 32'd3);
    chk("perf stalls at halt", PERF_STALLS, 32'd5);
`endif

    // PC wrap: redirect to FFFFFFFE -> fetch at FFFFFFFC, then 0
    wrap_word = 32'hDEAD_BEEF;
    cycle("wrap redir", 0, 0, 1, 32'hFFFF_FFFE, 1);
    chk("wrap redir addr", IM_ADDR, 32'hFFFF_FFFC);
    cycle("wrap fetch", 0, 0, 0, 0, 1);
    chk("wrap fetch pc", OUT_PC, 32'hFFFF_FFFC);
    chk("wrap fetch instr", OUT_INSTR, 32'hDEAD_BEEF);
    chk("wrap fetch addr", IM_ADDR, 32'h0);
    cycle("wrap next", 0, 0, 0, 0, 1);
    chk("wrap next pc", OUT_PC, 32'h0);
    chk("wrap next instr", OUT_INSTR, W0);
    wrap_word = '0;

    // randomized run against the model
    for (int i = 0; i < 16; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    cycle("rand rst", 1, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      cycle("rand",
            $urandom_range(0, 199) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0,
            32'($urandom_range(0, 70)),
            $urandom_range(0, 3) != 0);
      if (n % 500 == 499)
        for (int i = 0; i < 16; i++)
          rom_mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
